// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier that borrows the execute-stage ALU in add mode, one step per cycle.
// Optional MUL_EARLY_TERM_EN stops RUN once the remaining multiplier bits are all zero.
module alu_mul_sequencer #(
  parameter int N = 32,
  parameter logic [3:0] ADD_CODE = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic         flag_z,
  output logic         flag_n,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [N-1:0] acc, mcand, mplier, acc_next;
  logic [CW-1:0] count;
  logic last;
  assign alu_a = acc;
  assign alu_b = mcand;
  assign alu_ctrl = ADD_CODE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign acc_next = mplier[0] ? alu_result : acc;
`ifdef MUL_EARLY_TERM_EN
  assign last = (count == CW'(N - 1)) || ((mplier >> 1) == '0);
`else
  assign last = count == CW'(N - 1);
`endif
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = start ? RUN : IDLE;
      RUN:  state_next = last ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
      product <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        acc <= '0;
        mcand <= op_a;
        mplier <= op_b;
        count <= '0;
      end else if (state == RUN) begin
        acc <= acc_next;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        count <= count + 1'b1;
        // the final accumulate lands on the same edge that enters DONE
        if (last) begin
          product <= acc_next;
          flag_z <= acc_next == '0;
          flag_n <= acc_next[N-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed bench with a scoreboard of expected products and done latencies.
module tb_alu_mul_sequencer;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic busy, done, flag_z, flag_n;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl;
  int checks = 0, fails = 0, cyc = 0, t0 = 0;
  typedef struct {logic [31:0] p; int lat;} exp_t;
  exp_t sb[$];

  alu_mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .flag_z(flag_z), .flag_n(flag_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign alu_result = (alu_ctrl == 4'b0000) ? alu_a + alu_b : alu_a - alu_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
    int k = 32;
`ifdef MUL_EARLY_TERM_EN
    k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
`endif
    return k;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a = a; op_b = b; start = 1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 0;
    op_a = $urandom; op_b = $urandom;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.p = a * b;
    e.lat = exp_lat(b);
    sb.push_back(e);
    issue(a, b);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    exp_t e;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, cyc - t0, e.lat);
      chk({tag, "_product"}, product, e.p);
      chk({tag, "_flag_z"}, flag_z, e.p == 0);
      chk({tag, "_flag_n"}, flag_n, e.p[31]);
      chk({tag, "_busy_done"}, busy, 1);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_held"}, product, e.p);
    end
  endtask

  initial begin
    int extra;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_flags", {flag_z, flag_n}, 0);
    chk("alu_ctrl", alu_ctrl, 0);
    reset = 0;
    mul(32'd3, 32'd5);                 wait_done("m3x5");
    mul(32'hFFFF_FFFE, 32'd3);         wait_done("neg2x3");
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("neg1xneg1");
    mul(32'd7, 32'd0);                 wait_done("m7x0");
    mul(32'd9, 32'h8000_0000);         wait_done("m9xmsb");
    mul(32'd9, 32'h0000_000A);         wait_done("m9x10");
    mul(32'hDEAD_BEEF, 32'h1234_5678); wait_done("rand");
    mul(32'd6, 32'd7);
    @(negedge clk);
    op_a = 1; op_b = 1; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    wait_done("busy_start");
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("no_second_done", extra, 0);
    chk("product_kept", product, 42);
    issue(32'd6, 32'd7);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 0);
    chk("abort_flags", {flag_z, flag_n}, 0);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);
    mul(32'd2, 32'd2);                 wait_done("m2x2");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle controller that computes the low N bits of an unsigned/two's-complement product (ARM MUL semantics) by sequencing the shared combinational ALU in add mode, one shift-and-add step per cycle. It sits beside the ALU in the execute stage. While busy, it owns the ALU operand and control inputs. It returns the product plus Z/N flags to the issuing stage through a start/done handshake.

Parameters:
N, 32, operand/product width
ADD_CODE, 4'b0000, ALUControl value selecting addition (bit0=0, no operand inversion)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request a multiply; sampled only in IDLE
op_a  input  N  multiplicand, latched on accepted start
op_b  input  N  multiplier, latched on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when product valid
product  output  N  low N bits of op_a*op_b; held until next accepted start
flag_z  output  1  product==0, registered with product
flag_n  output  1  product[N-1], registered with product
alu_a  output  N  ALU operand A (accumulator)
alu_b  output  N  ALU operand B (shifted multiplicand)
alu_ctrl  output  4  ALU control; constant ADD_CODE
alu_result  input  N  ALU result, combinational from alu_a/alu_b

Behaviour:
- Clock clk; reset synchronous, active-high. This is already decided.
- Reset: state=IDLE; busy=0, done=0, product=0, flag_z=0, flag_n=0; internal acc/mcand/mplier/count=0.
- alu_ctrl=ADD_CODE at all times. alu_a=acc and alu_b=mcand at all times; only RUN-cycle results are used.
- IDLE: start=1 -> latch mcand=op_a, mplier=op_b, acc=0, count=0; next state RUN. start=0 -> stay.
- RUN, each cycle:
  - if mplier[0]: acc<=alu_result (wraps mod 2^N, carry discarded); else acc unchanged.
  - mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - Exit to DONE after the iteration with count==N-1 (N RUN cycles total).
- DONE: product<=acc, flag_z<=(acc==0), flag_n<=acc[N-1] on entry edge. done=1 for exactly this one cycle, busy=1. Next state IDLE unconditionally.
- Latency: start sampled at edge T; RUN cycles T+1..T+N; done high in cycle T+N+1. product/flags valid from that cycle and held thereafter. Next start accepted the cycle after done.
- start while busy (RUN/DONE) is ignored, not queued. op_a/op_b changes while busy have no effect.
- Signed operands produce the correct low N bits (two's-complement wrap); no high word, no overflow flag.
- Reset mid-operation: abort. Return to IDLE with all outputs at reset values, including the previous product.
- reset and start in the same cycle: reset wins.

Optional Feature:
Macro MUL_EARLY_TERM_EN.
- Defined: RUN also exits to DONE after any iteration whose shifted mplier (mplier>>1) is zero. RUN length = max(1, index of highest set bit of op_b + 1); done at T+k+1. op_b==0 gives one RUN cycle, with done at T+2.
- Undefined: fixed N RUN cycles regardless of operands; results are identical in both builds.

Test Plan:
- Reset, then op_a=3, op_b=5, start 1 cycle -> done at T+33 (N=32), product=15, flag_z=0, flag_n=0, busy high T+1..T+33.
- op_a=0xFFFFFFFE (-2), op_b=3 -> product=0xFFFFFFFA, flag_n=1; op_a=op_b=0xFFFFFFFF -> product=0x00000001.
- op_a=7, op_b=0 -> product=0, flag_z=1; with MUL_EARLY_TERM_EN, done at T+2; without, at T+33.
- With MUL_EARLY_TERM_EN, op_a=9, op_b=0x80000000 -> 32 RUN cycles, product=0x80000000. op_b=0x0000000A -> done at T+5, product=90.
- Start 6*7; pulse start with op_a=1, op_b=1 at T+10 -> ignored, product=42 at T+33, no second done.
- Start 6*7; assert reset at T+5 for 1 cycle -> busy=0, done never pulses, product=0. A fresh start 2*2 afterwards gives product=4.
